// File: rtl/mru_snapshot_serializer_if.sv
// Valid/ready beat bus carrying one history entry per beat, with its
// position in the snapshot and an end-of-snapshot marker.
interface mru_snapshot_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_idx;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_idx,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_idx,
    input  m_last,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/mru_snapshot_serializer.sv
// Snapshot serializer for the 4-entry distinct-value history tracker.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing to send; waiting for a tracker change with entry 0 valid
// SEND  | streaming cur[idx]; one pending snapshot may be parked in pend
//
// A change seen while a snapshot is in flight is parked in a single pending
// slot. A newer change overwrites the parked one and bumps drop_cnt. A change
// landing on the final accepted beat goes straight into cur so the next
// snapshot follows with no gap; that change also supersedes anything parked.
module mru_snapshot_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  mru_snapshot_serializer_if.master m,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_nxt;
  logic [3:0][DATA_W-1:0]  snap, prev;
  logic [3:0]              snap_v, prev_v;
  logic [3:0][DATA_W-1:0]  cur, cur_nxt;
  logic [3:0]              cur_v, cur_v_nxt;
  logic [3:0][DATA_W-1:0]  pend, pend_nxt;
  logic [3:0]              pend_v, pend_v_nxt;
  logic                    pend_flag, pend_flag_nxt;
  logic [1:0]              idx, idx_nxt, idx_inc;
  logic [7:0]              drop_nxt;
  logic                    drop_inc;
  logic                    change;
  logic                    last;
  logic                    accept;

  assign snap   = {in_3, in_2, in_1, in_0};
  assign snap_v = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  // Previous-cycle copy of the tracker; reset to the tracker's own reset state
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      prev   <= '0;
      prev_v <= '0;
    end else begin
      prev   <= snap;
      prev_v <= snap_v;
    end
  end

  // Snapshots without a valid newest entry carry nothing worth sending
  assign change = ((snap != prev) || (snap_v != prev_v)) && snap_v[0];

  // A zero flag ends the snapshot even if later flags are set
  assign idx_inc = idx + 2'd1;
  assign last    = (idx == 2'd3) || !cur_v[idx_inc];
  assign accept  = (state == SEND) && m.m_ready;

  assign m.m_valid = (state == SEND);
  assign m.m_data  = (state == SEND) ? cur[idx] : '0;
  assign m.m_idx   = (state == SEND) ? idx : 2'd0;
  assign m.m_last  = (state == SEND) && last;
  assign busy      = (state == SEND) || pend_flag;

  // Next-state and datapath decisions; all defaults hold current values
  always_comb begin
    state_nxt     = state;
    cur_nxt       = cur;
    cur_v_nxt     = cur_v;
    pend_nxt      = pend;
    pend_v_nxt    = pend_v;
    pend_flag_nxt = pend_flag;
    idx_nxt       = idx;
    drop_inc      = 1'b0;

    case (state)
      IDLE: begin
        if (change) begin
          cur_nxt   = snap;
          cur_v_nxt = snap_v;
          idx_nxt   = 2'd0;
          state_nxt = SEND;
        end
      end

      SEND: begin
        if (accept && last) begin
          if (change) begin
            // Fresh tracker state wins over anything parked
            cur_nxt       = snap;
            cur_v_nxt     = snap_v;
            idx_nxt       = 2'd0;
            drop_inc      = pend_flag;
            pend_flag_nxt = 1'b0;
          end else if (pend_flag) begin
            cur_nxt       = pend;
            cur_v_nxt     = pend_v;
            idx_nxt       = 2'd0;
            pend_flag_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (accept) begin
            idx_nxt = idx_inc;
          end
          if (change) begin
            pend_nxt      = snap;
            pend_v_nxt    = snap_v;
            pend_flag_nxt = 1'b1;
            drop_inc      = pend_flag;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign drop_nxt = (drop_inc && (drop_cnt != 8'hFF)) ? drop_cnt + 8'd1 : drop_cnt;

  // Control and snapshot registers; reset aborts any transfer at once
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= IDLE;
      cur       <= '0;
      cur_v     <= '0;
      pend      <= '0;
      pend_v    <= '0;
      pend_flag <= 1'b0;
      idx       <= 2'd0;
      drop_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      cur_v     <= cur_v_nxt;
      pend      <= pend_nxt;
      pend_v    <= pend_v_nxt;
      pend_flag <= pend_flag_nxt;
      idx       <= idx_nxt;
      drop_cnt  <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_mru_snapshot_serializer.sv
// Bench for the snapshot serializer: table of tracker snapshots plus
// hand-written overwrite, back-to-back and mid-transfer reset sequences.
module tb_mru_snapshot_serializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in0, in1, in2, in3;
  logic       iv0, iv1, iv2, iv3;
  logic       busy;
  logic [7:0] drop_cnt;

  mru_snapshot_serializer_if #(.DATA_W(8)) bus ();

  mru_snapshot_serializer #(.DATA_W(8)) dut (
    .clk_in     (clk),
    .reset_n_in (reset_n),
    .in_0       (in0),
    .in_1       (in1),
    .in_2       (in2),
    .in_3       (in3),
    .in_valid_0 (iv0),
    .in_valid_1 (iv1),
    .in_valid_2 (iv2),
    .in_valid_3 (iv3),
    .m          (bus),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0]      v;
    bit              toggle;
    int              exp_n;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[7];
  int    n_checks = 0;
  int    n_fail = 0;
  int    beats = 0;
  bit    stall_prev = 0;
  beat_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0][7:0] d, input logic [3:0] v);
    in0 = d[0]; in1 = d[1]; in2 = d[2]; in3 = d[3];
    iv0 = v[0]; iv1 = v[1]; iv2 = v[2]; iv3 = v[3];
  endtask

  // Expected beats: entries newest first, stopping at the first clear flag
  task automatic push_model(input logic [3:0][7:0] d, input logic [3:0] v);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) break;
      b.data = d[i];
      b.idx  = 2'(i);
      if (i == 3) b.last = 1'b1;
      else        b.last = !v[i+1];
      sb.push_back(b);
    end
  endtask

  // Observe outputs before the next rising edge, then move to the next low phase
  task automatic step();
    beat_t b;
    #1;
    if (reset_n) begin
      if (stall_prev) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_data", bus.m_data, held.data);
        chk("hold_idx", bus.m_idx, held.idx);
        chk("hold_last", bus.m_last, held.last);
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held = '{data: bus.m_data, idx: bus.m_idx, last: bus.m_last};
      if (bus.m_valid && bus.m_ready) begin
        beats++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h idx %0d, expected no beat", bus.m_data, bus.m_idx);
        end else begin
          b = sb.pop_front();
          chk("beat_data", bus.m_data, b.data);
          chk("beat_idx", bus.m_idx, b.idx);
          chk("beat_last", bus.m_last, b.last);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit toggle, output int cyc);
    bit done = 0;
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      if (toggle) bus.m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      else        bus.m_ready = 1'b1;
      step();
      cyc++;
      if (sb.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats still pending, expected 0", sb.size());
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{d: {8'h00, 8'h00, 8'h00, 8'h11}, v: 4'b0001, toggle: 0, exp_n: 1};
    vecs[1] = '{d: {8'h11, 8'h22, 8'h33, 8'h44}, v: 4'b1111, toggle: 0, exp_n: 4};
    vecs[2] = '{d: {8'hD1, 8'hC2, 8'hB3, 8'hA4}, v: 4'b1111, toggle: 1, exp_n: 4};
    vecs[3] = '{d: {8'h04, 8'h03, 8'h02, 8'h01}, v: 4'b0011, toggle: 0, exp_n: 2};
    vecs[4] = '{d: {8'h0D, 8'h0C, 8'h0B, 8'h0A}, v: 4'b0111, toggle: 1, exp_n: 3};
    vecs[5] = '{d: {8'h40, 8'h30, 8'h20, 8'h10}, v: 4'b1101, toggle: 0, exp_n: 1};
    vecs[6] = '{d: {8'h99, 8'h98, 8'h97, 8'h96}, v: 4'b0000, toggle: 0, exp_n: 0};

    drive('0, 4'b0000);
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_idx", bus.m_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    reset_n = 1'b1;
    bus.m_ready = 1'b1;
    repeat (3) step();
    chk("idle_after_rst", bus.m_valid, 0);

    for (int i = 0; i < 7; i++) begin
      beats = 0;
      drive(vecs[i].d, vecs[i].v);
      push_model(vecs[i].d, vecs[i].v);
      drain(vecs[i].toggle, cyc);
      if (!vecs[i].toggle) chk("vec_cycles", 32'(cyc), 32'(vecs[i].exp_n + 1));
      chk("vec_beats", 32'(beats), 32'(vecs[i].exp_n));
      chk("vec_busy", busy, 0);
      chk("vec_valid", bus.m_valid, 0);
    end
    chk("drop_after_table", drop_cnt, 0);

    // Two changes during a stalled transfer: only the newer one survives
    drive({8'h11, 8'h22, 8'h33, 8'h44}, 4'b1111);
    push_model({8'h11, 8'h22, 8'h33, 8'h44}, 4'b1111);
    bus.m_ready = 1'b0;
    step();
    step();
    in0 = 8'h55;
    step();
    chk("ovr_drop0", drop_cnt, 0);
    chk("ovr_busy", busy, 1);
    step();
    in0 = 8'h66;
    step();
    chk("ovr_drop1", drop_cnt, 1);
    push_model({8'h11, 8'h22, 8'h33, 8'h66}, 4'b1111);
    drain(0, cyc);
    chk("ovr_b2b_cycles", 32'(cyc), 8);

    // Change on the final accepted beat starts the next snapshot with no gap
    drive({8'h11, 8'h22, 8'h33, 8'h77}, 4'b0001);
    push_model({8'h11, 8'h22, 8'h33, 8'h77}, 4'b0001);
    bus.m_ready = 1'b1;
    step();
    in0 = 8'h78;
    push_model({8'h11, 8'h22, 8'h33, 8'h78}, 4'b0001);
    step();
    chk("b2b_valid", bus.m_valid, 1);
    chk("b2b_data", bus.m_data, 8'h78);
    drain(0, cyc);
    chk("b2b_cycles", 32'(cyc), 1);
    chk("b2b_drop", drop_cnt, 1);

    // Reset during beat 2 aborts the transfer
    drive({8'h24, 8'h23, 8'h22, 8'h21}, 4'b1111);
    push_model({8'h24, 8'h23, 8'h22, 8'h21}, 4'b1111);
    bus.m_ready = 1'b1;
    step();
    step();
    step();
    chk("mid_idx", bus.m_idx, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.m_valid, 0);
    chk("arst_last", bus.m_last, 0);
    chk("arst_data", bus.m_data, 0);
    chk("arst_idx", bus.m_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drop", drop_cnt, 0);
    sb.delete();
    stall_prev = 0;
    drive('0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_rst_quiet", bus.m_valid, 0);
    end
    chk("post_rst_busy", busy, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mru_snapshot_serializer.md
# mru_snapshot_serializer

Downstream stage of the 4-entry distinct-value history tracker. It watches the tracker's four entries and valid flags every cycle. Whenever the snapshot changes, it captures it and streams the valid entries, newest first, over a valid/ready master interface with index and last markers. One pending-snapshot slot absorbs changes that arrive during a transfer; snapshots lost to overwrite are counted.

## Interface
- DATA_W, 8, width of each history entry
- clk_in  in  1  single clock, rising edge
- reset_n_in  in  1  asynchronous, active-low reset
- in_0 .. in_3  in  DATA_W each  tracker entries; in_0 is newest
- in_valid_0 .. in_valid_3  in  1 each  tracker valid flags; thermometer coded from 0
- m_data  out  DATA_W  entry being emitted
- m_idx  out  2  entry position (0..3) of m_data
- m_last  out  1  high on the final valid entry of the snapshot
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- busy  out  1  transfer in progress or snapshot pending
- drop_cnt  out  8  snapshots overwritten in pending slot, saturates at 255

## Operation
- prev register holds last-cycle copy of all in_* and in_valid_*; updated every cycle; reset value all zero, which matches the tracker's reset state, so no spurious change is detected.
- change = any bit of {in_0..3, in_valid_0..3} differs from prev AND in_valid_0 = 1. Snapshots with no valid entry are ignored.
- Registers: cur[0:3], cur_v[0:3] (snapshot being sent), pend[0:3], pend_v[0:3], pend_flag, idx[1:0], state {IDLE, SEND}, drop_cnt.
- IDLE: on change, load cur/cur_v from inputs, idx = 0, go to SEND.
- SEND: m_valid = 1, m_data = cur[idx], m_idx = idx, m_last = (idx == 3) OR (cur_v[idx+1] == 0).
- Accept = m_valid AND m_ready.
  - Accept with m_last = 0: idx increments.
  - Accept with m_last = 1, and this cycle's change set: load cur from inputs, idx = 0, stay in SEND. Any pend_flag content is discarded, drop_cnt increments, and pend_flag clears.
  - Otherwise accept with m_last = 1 and pend_flag = 1: load cur from pend, clear pend_flag, idx = 0, stay in SEND.
  - Otherwise accept with m_last = 1: go to IDLE.
- Change in SEND without a last accept: write pend from inputs and set pend_flag. If pend_flag was already 1, drop_cnt increments (newest snapshot wins).
- Non-thermometer cur_v: entries after the first 0 flag are never sent.
- busy = (state == SEND) OR pend_flag.
- drop_cnt saturates at 255 and is cleared only by reset.

## Timing
- Reset (reset_n_in low, asynchronous): state IDLE, m_valid 0, m_last 0, m_data 0, m_idx 0, busy 0, drop_cnt 0, pend_flag 0, prev/cur/pend all zero.
- Change sampled at edge N drives m_valid high in cycle N+1. Latency is 1 cycle.
- m_data, m_idx and m_last are held stable while m_valid = 1 and m_ready = 0. m_valid never drops without an accept.
- Back-to-back snapshots: no idle cycle between the last beat of one snapshot and beat 0 of the next.
- Full 4-entry snapshot with m_ready held high takes 4 cycles.
- Reset asserted mid-transfer aborts immediately. No beat is emitted until a new change after reset release.

## Test plan
- Reset then one tracker update in_0 = 0x11, in_valid = 1000 -> one cycle later a single beat: m_data 0x11, m_idx 0, m_last 1. Then IDLE, busy 0.
- Snapshot {0x44, 0x33, 0x22, 0x11}, all valid, m_ready high -> 4 consecutive beats 0x44, 0x33, 0x22, 0x11 with m_idx 0..3 and m_last only on the 4th.
- Same snapshot with m_ready toggling 1, 0, 0, 1, … -> each beat held stable while m_ready = 0. Sequence and count unchanged.
- During a 4-beat transfer with m_ready low, apply two further changes (0x55 then 0x66 on in_0) -> drop_cnt = 1. After the first snapshot finishes, only the 0x66 snapshot follows, back-to-back.
- Change coincident with the m_last accept, pend_flag = 0 -> new snapshot beat 0 in the next cycle, no IDLE gap, drop_cnt unchanged.
- Pull reset_n_in low during beat 2 -> all outputs return to reset values asynchronously. After release with inputs unchanged from the tracker's reset zeros, no beats are emitted.
